// File: rtl/dcache_replacer.sv
// Replacement sequencer for the direct-mapped D$ line array and its single line-wide memory port.
// Runs write-through, replace (write back + refill) and invalidate commands, plus the post-reset valid sweep.
module dcache_replacer #(
  parameter int INDEX_WIDTH    = 4,
  parameter int TAG_WIDTH      = 26,
  parameter int LINE_WIDTH     = 128,
  parameter int MEM_ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [1:0]                command,
  input  logic [INDEX_WIDTH-1:0]    commandIndex,
  input  logic [TAG_WIDTH-1:0]      commandTag,
  input  logic [LINE_WIDTH-1:0]     commandData,
  output logic                      ready,
  output logic                      done,

  output logic [INDEX_WIDTH-1:0]    arrayReadIndex,
  input  logic                      arrayReadValid,
  input  logic                      arrayReadDirty,
  input  logic [TAG_WIDTH-1:0]      arrayReadTag,
  input  logic [LINE_WIDTH-1:0]     arrayReadData,
  output logic                      arrayWriteEnable,
  output logic [INDEX_WIDTH-1:0]    arrayWriteIndex,
  output logic                      arrayWriteValid,
  output logic                      arrayWriteDirty,
  output logic [TAG_WIDTH-1:0]      arrayWriteTag,
  output logic [LINE_WIDTH-1:0]     arrayWriteData,

  output logic [MEM_ADDR_WIDTH-1:0] memAddr,
  output logic                      memReadEnable,
  output logic                      memWriteEnable,
  output logic [LINE_WIDTH-1:0]     memWriteValue,
  input  logic [LINE_WIDTH-1:0]     memReadValue,
  input  logic                      memDone
);

  typedef enum logic [1:0] {
    CMD_NONE          = 2'd0,
    CMD_WRITE_THROUGH = 2'd1,
    CMD_REPLACE       = 2'd2,
    CMD_INVALIDATE    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_READ_ARRAY,
    S_JUDGE,
    S_WRITE_BACK,
    S_REFILL,
    S_WRITE_ARRAY,
    S_WRITE_THROUGH
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  sweep_q;
  logic                    done_q;

  cmd_e                    cmd_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  // Holds the write-through line, or the refill line for a replace; never both at once.
  logic [LINE_WIDTH-1:0]   line_q;
  logic [TAG_WIDTH-1:0]    victim_tag_q;
  logic [LINE_WIDTH-1:0]   victim_line_q;

  logic                    victim_dirty;
  logic                    accept;

  assign victim_dirty = arrayReadValid & arrayReadDirty;
  assign accept       = (state_q == S_IDLE) && (cmd_e'(command) != CMD_NONE);
  assign done         = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      sweep_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RESET) sweep_q <= sweep_q + 1'b1;
      done_q  <= (state_d == S_IDLE) && (state_q != S_IDLE) && (state_q != S_RESET);
    end
  end

  // NOTE: command/victim/line registers are pure datapath, qualified by the
  // FSM before use, so they carry no reset and stay cheap wide flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q   <= cmd_e'(command);
      index_q <= commandIndex;
      tag_q   <= commandTag;
      line_q  <= commandData;
    end
    if (state_q == S_JUDGE) begin
      victim_tag_q  <= arrayReadTag;
      victim_line_q <= arrayReadData;
    end
    if (state_q == S_REFILL && memDone) line_q <= memReadValue;
  end

  // NOTE: every output and state_d gets a default before the case so no
  // path through this block leaves a value unassigned (no inferred latch).
  always_comb begin
    state_d          = state_q;
    ready            = 1'b0;
    arrayReadIndex   = '0;
    arrayWriteEnable = 1'b0;
    arrayWriteIndex  = '0;
    arrayWriteValid  = 1'b0;
    arrayWriteDirty  = 1'b0;
    arrayWriteTag    = '0;
    arrayWriteData   = '0;
    memAddr          = '0;
    memReadEnable    = 1'b0;
    memWriteEnable   = 1'b0;
    memWriteValue    = '0;

    case (state_q)
      S_RESET: begin
        arrayWriteEnable = 1'b1;
        arrayWriteIndex  = sweep_q;
        if (&sweep_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        if (accept)
          state_d = (cmd_e'(command) == CMD_WRITE_THROUGH) ? S_WRITE_THROUGH : S_READ_ARRAY;
      end
      S_READ_ARRAY: begin
        arrayReadIndex = index_q;
        state_d        = S_JUDGE;
      end
      S_JUDGE: begin
        if (victim_dirty)              state_d = S_WRITE_BACK;
        else if (cmd_q == CMD_REPLACE) state_d = S_REFILL;
        else                           state_d = S_WRITE_ARRAY;
      end
      S_WRITE_BACK: begin
        memWriteEnable = 1'b1;
        memAddr        = {victim_tag_q, index_q};
        memWriteValue  = victim_line_q;
        if (memDone) state_d = (cmd_q == CMD_REPLACE) ? S_REFILL : S_WRITE_ARRAY;
      end
      S_REFILL: begin
        memReadEnable = 1'b1;
        memAddr       = {tag_q, index_q};
        if (memDone) state_d = S_WRITE_ARRAY;
      end
      S_WRITE_ARRAY: begin
        arrayWriteEnable = 1'b1;
        arrayWriteIndex  = index_q;
        if (cmd_q == CMD_REPLACE) begin
          arrayWriteValid = 1'b1;
          arrayWriteTag   = tag_q;
          arrayWriteData  = line_q;
        end
        state_d = S_IDLE;
      end
      S_WRITE_THROUGH: begin
        memWriteEnable = 1'b1;
        memAddr        = {tag_q, index_q};
        memWriteValue  = line_q;
        if (memDone) state_d = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase

    // During reset the state register already reads S_RESET; keep the sweep
    // strobe and everything else quiet until rst is released.
    if (rst) begin
      ready            = 1'b0;
      arrayReadIndex   = '0;
      arrayWriteEnable = 1'b0;
      arrayWriteIndex  = '0;
      arrayWriteValid  = 1'b0;
      arrayWriteDirty  = 1'b0;
      arrayWriteTag    = '0;
      arrayWriteData   = '0;
      memAddr          = '0;
      memReadEnable    = 1'b0;
      memWriteEnable   = 1'b0;
      memWriteValue    = '0;
    end
  end

endmodule

// File: tb/tb_dcache_replacer.sv
// Randomized self-checking bench for dcache_replacer: a line-array and memory responder plus a
// transaction-level reference model that predicts memory traffic, array writes and latency.
module tb_dcache_replacer;

  localparam int IW = 4;
  localparam int TW = 26;
  localparam int LW = 128;
  localparam int AW = 30;
  localparam int N  = 1 << IW;

  localparam logic [1:0] C_WT  = 2'd1;
  localparam logic [1:0] C_RP  = 2'd2;
  localparam logic [1:0] C_INV = 2'd3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] value;
  } mem_op_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic          valid;
    logic          dirty;
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } arr_wr_t;

  logic          clk, rst;
  logic [1:0]    command;
  logic [IW-1:0] commandIndex;
  logic [TW-1:0] commandTag;
  logic [LW-1:0] commandData;
  logic          ready, done;
  logic [IW-1:0] arrayReadIndex;
  logic          arrayReadValid, arrayReadDirty;
  logic [TW-1:0] arrayReadTag;
  logic [LW-1:0] arrayReadData;
  logic          arrayWriteEnable;
  logic [IW-1:0] arrayWriteIndex;
  logic          arrayWriteValid, arrayWriteDirty;
  logic [TW-1:0] arrayWriteTag;
  logic [LW-1:0] arrayWriteData;
  logic [AW-1:0] memAddr;
  logic          memReadEnable, memWriteEnable;
  logic [LW-1:0] memWriteValue, memReadValue;
  logic          memDone;

  dcache_replacer dut (
    .clk(clk), .rst(rst),
    .command(command), .commandIndex(commandIndex), .commandTag(commandTag),
    .commandData(commandData), .ready(ready), .done(done),
    .arrayReadIndex(arrayReadIndex), .arrayReadValid(arrayReadValid),
    .arrayReadDirty(arrayReadDirty), .arrayReadTag(arrayReadTag), .arrayReadData(arrayReadData),
    .arrayWriteEnable(arrayWriteEnable), .arrayWriteIndex(arrayWriteIndex),
    .arrayWriteValid(arrayWriteValid), .arrayWriteDirty(arrayWriteDirty),
    .arrayWriteTag(arrayWriteTag), .arrayWriteData(arrayWriteData),
    .memAddr(memAddr), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memWriteValue(memWriteValue), .memReadValue(memReadValue), .memDone(memDone)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Line array seen by the DUT, and the reference model's view of it.
  logic          env_valid [N];
  logic          env_dirty [N];
  logic [TW-1:0] env_tag   [N];
  logic [LW-1:0] env_data  [N];
  logic          sh_valid  [N];
  logic          sh_dirty  [N];
  logic [TW-1:0] sh_tag    [N];
  logic [LW-1:0] sh_data   [N];

  mem_op_t mem_log[$];
  mem_op_t exp_mem[$];
  arr_wr_t arr_log[$];
  arr_wr_t exp_arr[$];
  int      exp_lat;
  int      mem_lat = 1;
  int      acc_cyc, done_cyc;
  logic [LW-1:0] refill_line;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Registered line array: index seen in one cycle returns data in the next.
  initial begin
    logic [IW-1:0] pend;
    pend = '0;
    arrayReadValid = 1'b0; arrayReadDirty = 1'b0; arrayReadTag = '0; arrayReadData = '0;
    forever begin
      @(negedge clk);
      arrayReadValid = env_valid[pend];
      arrayReadDirty = env_dirty[pend];
      arrayReadTag   = env_tag[pend];
      arrayReadData  = env_data[pend];
      if (arrayWriteEnable) begin
        arr_wr_t w;
        w.idx = arrayWriteIndex; w.valid = arrayWriteValid; w.dirty = arrayWriteDirty;
        w.tag = arrayWriteTag;   w.data  = arrayWriteData;
        env_valid[w.idx] = w.valid; env_dirty[w.idx] = w.dirty;
        env_tag[w.idx]   = w.tag;   env_data[w.idx]  = w.data;
        arr_log.push_back(w);
      end
      pend = arrayReadIndex;
    end
  end

  // Memory responder: completes each request in its mem_lat-th enable cycle.
  initial begin
    int            en_cycles;
    logic [AW-1:0] first_addr;
    logic [LW-1:0] first_val;
    logic          first_we;
    en_cycles = 0; first_addr = '0; first_val = '0; first_we = 1'b0;
    memDone = 1'b0;
    forever begin
      @(negedge clk);
      if (memDone) en_cycles = 0;
      memDone = 1'b0;
      if (rst || !(memReadEnable || memWriteEnable)) begin
        en_cycles = 0;
      end else begin
        check("mem_exclusive", memReadEnable & memWriteEnable, 1'b0);
        en_cycles++;
        if (en_cycles == 1) begin
          first_addr = memAddr; first_val = memWriteValue; first_we = memWriteEnable;
        end else begin
          check("mem_addr_stable", memAddr, first_addr);
          check("mem_kind_stable", memWriteEnable, first_we);
          if (first_we) check("mem_value_stable", memWriteValue, first_val);
        end
        if (en_cycles >= mem_lat) begin
          mem_op_t op;
          op.we = memWriteEnable; op.addr = memAddr;
          op.value = memWriteEnable ? memWriteValue : '0;
          mem_log.push_back(op);
          memDone = 1'b1;
        end
      end
    end
  end

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_mem(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] value);
    mem_op_t op;
    op.we = we; op.addr = addr; op.value = value;
    exp_mem.push_back(op);
  endtask

  // Reference model: expected traffic, array write and latency from the command rules.
  task automatic ref_expect(input logic [1:0] c, input logic [IW-1:0] idx,
                            input logic [TW-1:0] tg, input logic [LW-1:0] dt, input int lat);
    logic    dirty_victim;
    arr_wr_t w;
    exp_mem.delete();
    exp_arr.delete();
    dirty_victim = sh_valid[idx] && sh_dirty[idx];
    if (c == C_WT) begin
      push_mem(1'b1, {tg, idx}, dt);
      exp_lat = lat + 1;
    end else begin
      if (dirty_victim) push_mem(1'b1, {sh_tag[idx], idx}, sh_data[idx]);
      w.idx = idx; w.dirty = 1'b0;
      if (c == C_RP) begin
        push_mem(1'b0, {tg, idx}, '0);
        w.valid = 1'b1; w.tag = tg; w.data = refill_line;
        exp_lat = 3 + (dirty_victim ? 2 * lat : lat) + 1;
      end else begin
        w.valid = 1'b0; w.tag = '0; w.data = '0;
        exp_lat = dirty_victim ? 3 + lat + 1 : 4;
      end
      exp_arr.push_back(w);
      sh_valid[idx] = w.valid; sh_dirty[idx] = 1'b0; sh_tag[idx] = w.tag; sh_data[idx] = w.data;
    end
  endtask

  task automatic preload(input logic [IW-1:0] idx, input logic v, input logic d,
                         input logic [TW-1:0] tg, input logic [LW-1:0] dt);
    env_valid[idx] = v; env_dirty[idx] = d; env_tag[idx] = tg; env_data[idx] = dt;
    sh_valid[idx]  = v; sh_dirty[idx]  = d; sh_tag[idx]  = tg; sh_data[idx]  = dt;
  endtask

  // Called at a falling edge; presents the command and waits for it to be accepted.
  task automatic issue(input logic [1:0] c, input logic [IW-1:0] idx,
                       input logic [TW-1:0] tg, input logic [LW-1:0] dt, input int lat);
    int waited = 0;
    command = c; commandIndex = idx; commandTag = tg; commandData = dt;
    mem_lat = lat;
    memReadValue = refill_line;
    ref_expect(c, idx, tg, dt, lat);
    while (!ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", ready, 1'b1);
    acc_cyc = cyc;
    mem_log.delete();
    arr_log.delete();
    @(posedge clk);
    #1 command = 2'd0;
  endtask

  task automatic complete(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      check({name, "_busy_not_ready"}, ready, 1'b0);
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done, 1'b1);
    if (!done) return;
    done_cyc = cyc;
    check({name, "_latency"}, cyc - acc_cyc, exp_lat);
    check({name, "_ready_at_done"}, ready, 1'b1);
    check({name, "_mem_op_count"}, mem_log.size(), exp_mem.size());
    for (int i = 0; i < mem_log.size() && i < exp_mem.size(); i++) begin
      check({name, "_mem_we"}, mem_log[i].we, exp_mem[i].we);
      check({name, "_mem_addr"}, mem_log[i].addr, exp_mem[i].addr);
      if (exp_mem[i].we) check({name, "_mem_wdata"}, mem_log[i].value, exp_mem[i].value);
    end
    check({name, "_arr_write_count"}, arr_log.size(), exp_arr.size());
    for (int i = 0; i < arr_log.size() && i < exp_arr.size(); i++) begin
      check({name, "_arr_idx"}, arr_log[i].idx, exp_arr[i].idx);
      check({name, "_arr_vdt"}, {arr_log[i].valid, arr_log[i].dirty, arr_log[i].tag},
            {exp_arr[i].valid, exp_arr[i].dirty, exp_arr[i].tag});
      check({name, "_arr_data"}, arr_log[i].data, exp_arr[i].data);
    end
    if (exp_arr.size() > 0) begin
      logic [IW-1:0] k;
      k = exp_arr[0].idx;
      check({name, "_entry_state"}, {env_valid[k], env_dirty[k], env_tag[k]},
            {sh_valid[k], sh_dirty[k], sh_tag[k]});
    end
  endtask

  // Called at a falling edge: asserts rst, checks quiet outputs, then checks the full sweep.
  task automatic do_reset();
    rst = 1'b1;
    command = 2'd0;
    #1;
    check("rst_outputs_zero",
          |{ready, done, arrayReadIndex, arrayWriteEnable, arrayWriteIndex, arrayWriteValid,
            arrayWriteDirty, arrayWriteTag, arrayWriteData, memAddr, memReadEnable,
            memWriteEnable, memWriteValue}, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("rst_quiet", {done, arrayWriteEnable, memReadEnable, memWriteEnable}, 4'b0);
    end
    rst = 1'b0;
    for (int k = 0; k <= N; k++) begin
      #1;
      if (k < N) begin
        check("sweep_we", arrayWriteEnable, 1'b1);
        check("sweep_idx", arrayWriteIndex, k[IW-1:0]);
        check("sweep_vd", {arrayWriteValid, arrayWriteDirty}, 2'b00);
        check("sweep_not_ready", ready, 1'b0);
      end else begin
        check("sweep_ready_after", ready, 1'b1);
        check("sweep_we_after", arrayWriteEnable, 1'b0);
      end
      check("sweep_no_done", done, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      sh_valid[i] = 1'b0; sh_dirty[i] = 1'b0; sh_tag[i] = '0; sh_data[i] = '0;
    end
    check("sweep_cleared_entries", env_valid[5] | env_valid[N-1], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d;
    rst = 1'b1;
    command = 2'd0; commandIndex = '0; commandTag = '0; commandData = '0;
    memReadValue = '0; refill_line = '0;
    for (int i = 0; i < N; i++) begin
      env_valid[i] = 1'b1; env_dirty[i] = 1'b1; env_tag[i] = TW'(i); env_data[i] = '1;
    end
    @(negedge clk);
    do_reset();

    // Replace into an invalid entry.
    refill_line = {16{8'hA5}};
    issue(C_RP, 4'd5, 26'h123, '0, 3);
    complete("replace_clean");
    check("replace_clean_addr", exp_mem[0].addr, 30'h1235);

    // Replace of a dirty victim: write back first, then refill.
    d = rand_line();
    preload(4'd2, 1'b1, 1'b1, 26'h7, d);
    refill_line = rand_line();
    issue(C_RP, 4'd2, 26'h9, rand_line(), 2);
    complete("replace_dirty");

    // Invalidate dirty, then invalidate clean.
    preload(4'd7, 1'b1, 1'b1, 26'h3ABCDE, rand_line());
    issue(C_INV, 4'd7, 26'h0, '0, 2);
    complete("inval_dirty");
    preload(4'd8, 1'b1, 1'b0, 26'h55, rand_line());
    issue(C_INV, 4'd8, 26'h0, '0, 3);
    complete("inval_clean");

    // Write-through with L=1 while a Replace is held on the command port.
    issue(C_WT, 4'd4, 26'h2BEEF, {4{32'hDEADBEEF}}, 1);
    command = C_RP; commandIndex = 4'd11; commandTag = 26'h77; commandData = '0;
    complete("write_through");
    refill_line = rand_line();
    issue(C_RP, 4'd11, 26'h77, '0, 2);
    check("held_accept_cycle", acc_cyc, done_cyc);
    complete("held_replace");

    // Reset while a refill is outstanding.
    refill_line = rand_line();
    issue(C_RP, 4'd3, 26'h1F00F, '0, 10);
    for (int n = 0; n < 20 && !memReadEnable; n++) @(negedge clk);
    check("refill_reached", memReadEnable, 1'b1);
    do_reset();

    // Randomized command mix against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [IW-1:0] idx;
      logic [1:0]    c;
      idx = IW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) != 0)
        preload(idx, 1'($urandom), 1'($urandom), TW'($urandom), rand_line());
      c = 2'($urandom_range(1, 3));
      refill_line = rand_line();
      issue(c, idx, TW'($urandom), rand_line(), $urandom_range(1, 4));
      complete("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
